rs_issue_operand_latch: RTL and testbench

- Issue-stage operand latch directly downstream of the reservation-station wakeup data arrays (A, B and S/flags).
- Captures per-port operands read from the RS on the three issue ports and presents them to the functional units one cycle later.
- Keeps snooping the FU writeback/flags buses, so operands still pending at read time are completed in place.
- Has a 1-deep skid buffer per port, so a late FU stall never drops an issued instruction.

---
 rtl/rs_issue_operand_latch_if.sv | 52 +++++
 rtl/rs_issue_operand_latch.sv | 133 +++++++++++++
 tb/tb_rs_issue_operand_latch.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_operand_latch_if.sv
// Bundle of issue-port, writeback-snoop and FU-facing signals for the operand latch.
// The master side is the RS select / writeback network; the slave side is the latch.
// Widths follow the latch parameters; all signals are single-cycle, core-clocked.
interface rs_issue_operand_latch_if #(
  parameter int DATA_WIDTH  = 65,
  parameter int REG_WIDTH   = 9,
  parameter int FLAGS_WIDTH = 6,
  parameter int FU_COUNT    = 10
);
  // Downstream stall shared by all three issue ports
  logic                                 stall;

  // Issue side: operands read from the RS arrays
  logic [2:0]                           in_vld;
  logic [2:0]                           in_rdy;
  logic [3*DATA_WIDTH-1:0]              in_dataA;
  logic [3*DATA_WIDTH-1:0]              in_dataB;
  logic [3*FLAGS_WIDTH-1:0]             in_dataS;
  logic [2:0]                           in_pendA;
  logic [2:0]                           in_pendB;
  logic [2:0]                           in_pendS;
  logic [3*REG_WIDTH-1:0]               in_regA;
  logic [3*REG_WIDTH-1:0]               in_regB;
  logic [3*REG_WIDTH-1:0]               in_regS;

  // Writeback buses being snooped
  logic [FU_COUNT*DATA_WIDTH-1:0]       FU_data;
  logic [FU_COUNT*REG_WIDTH-1:0]        FU_reg;
  logic [FU_COUNT-1:0]                  FU_wen;
  logic [(FU_COUNT-1)*FLAGS_WIDTH-1:0]  FUS;

  // FU side: latched operands
  logic [2:0]                           out_vld;
  logic [2:0]                           out_go;
  logic [3*DATA_WIDTH-1:0]              out_dataA;
  logic [3*DATA_WIDTH-1:0]              out_dataB;
  logic [3*FLAGS_WIDTH-1:0]             out_dataS;

  modport master (
    output stall, in_vld, in_dataA, in_dataB, in_dataS,
           in_pendA, in_pendB, in_pendS, in_regA, in_regB, in_regS,
           FU_data, FU_reg, FU_wen, FUS,
    input  in_rdy, out_vld, out_go, out_dataA, out_dataB, out_dataS
  );

  modport slave (
    input  stall, in_vld, in_dataA, in_dataB, in_dataS,
           in_pendA, in_pendB, in_pendS, in_regA, in_regB, in_regS,
           FU_data, FU_reg, FU_wen, FUS,
    output in_rdy, out_vld, out_go, out_dataA, out_dataB, out_dataS
  );
endinterface

// File: rtl/rs_issue_operand_latch.sv
// Issue-stage operand latch: captures RS operands per port and completes pending ones by snooping writeback.
// Latency: one cycle from accept to out_* when the main entry advances; otherwise after the skid drains.
// Backpressure: stall (or an unready main entry) holds main; a 1-deep skid absorbs one more issue, in_rdy = ~skid_vld.
module rs_issue_operand_latch #(
  parameter int DATA_WIDTH  = 65,
  parameter int REG_WIDTH   = 9,
  parameter int FLAGS_WIDTH = 6,
  parameter int FU_COUNT    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  rs_issue_operand_latch_if.slave bus
);

  localparam int PORTS = 3;

  // One stored instruction's operand set
  typedef struct packed {
    logic                   vld;
    logic [DATA_WIDTH-1:0]  data_a;
    logic [DATA_WIDTH-1:0]  data_b;
    logic [FLAGS_WIDTH-1:0] data_s;
    logic                   pend_a;
    logic                   pend_b;
    logic                   pend_s;
    logic [REG_WIDTH-1:0]   reg_a;
    logic [REG_WIDTH-1:0]   reg_b;
    logic [REG_WIDTH-1:0]   reg_s;
  } entry_t;

  // Completes pending operands from this cycle's writeback buses.
  // Loops run from the highest index down so the lowest matching FU is
  // assigned last and therefore wins. Flags buses stop at FU_COUNT-2.
  function automatic entry_t snoop(
    input entry_t                              e,
    input logic [FU_COUNT*DATA_WIDTH-1:0]      fd,
    input logic [FU_COUNT*REG_WIDTH-1:0]       fr,
    input logic [FU_COUNT-1:0]                 fw,
    input logic [(FU_COUNT-1)*FLAGS_WIDTH-1:0] fs
  );
    entry_t r;
    r = e;
    for (int k = FU_COUNT-1; k >= 0; k--) begin
      if (e.pend_a && fw[k] && (fr[k*REG_WIDTH +: REG_WIDTH] == e.reg_a)) begin
        r.data_a = fd[k*DATA_WIDTH +: DATA_WIDTH];
        r.pend_a = 1'b0;
      end
      if (e.pend_b && fw[k] && (fr[k*REG_WIDTH +: REG_WIDTH] == e.reg_b)) begin
        r.data_b = fd[k*DATA_WIDTH +: DATA_WIDTH];
        r.pend_b = 1'b0;
      end
    end
    for (int k = FU_COUNT-2; k >= 0; k--) begin
      if (e.pend_s && fw[k] && (fr[k*REG_WIDTH +: REG_WIDTH] == e.reg_s)) begin
        r.data_s = fs[k*FLAGS_WIDTH +: FLAGS_WIDTH];
        r.pend_s = 1'b0;
      end
    end
    return r;
  endfunction

  for (genvar gp = 0; gp < PORTS; gp++) begin : g_port
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in;
    entry_t w_in_snp;
    entry_t w_main_snp;
    entry_t w_skid_snp;
    logic   w_go;
    logic   w_adv;
    logic   w_acc;

    // Unpack this port's slice of the issue bus into an entry
    always_comb begin
      w_in        = '0;
      w_in.vld    = bus.in_vld[gp];
      w_in.data_a = bus.in_dataA[gp*DATA_WIDTH +: DATA_WIDTH];
      w_in.data_b = bus.in_dataB[gp*DATA_WIDTH +: DATA_WIDTH];
      w_in.data_s = bus.in_dataS[gp*FLAGS_WIDTH +: FLAGS_WIDTH];
      w_in.pend_a = bus.in_pendA[gp];
      w_in.pend_b = bus.in_pendB[gp];
      w_in.pend_s = bus.in_pendS[gp];
      w_in.reg_a  = bus.in_regA[gp*REG_WIDTH +: REG_WIDTH];
      w_in.reg_b  = bus.in_regB[gp*REG_WIDTH +: REG_WIDTH];
      w_in.reg_s  = bus.in_regS[gp*REG_WIDTH +: REG_WIDTH];
    end

    // Every value that can be written this cycle sees the same broadcasts
    assign w_in_snp   = snoop(w_in,   bus.FU_data, bus.FU_reg, bus.FU_wen, bus.FUS);
    assign w_main_snp = snoop(r_main, bus.FU_data, bus.FU_reg, bus.FU_wen, bus.FUS);
    assign w_skid_snp = snoop(r_skid, bus.FU_data, bus.FU_reg, bus.FU_wen, bus.FUS);

    // A valid main entry waiting on an operand blocks the port like a stall
    always_comb begin
      w_go  = r_main.vld & ~r_main.pend_a & ~r_main.pend_b & ~r_main.pend_s;
      w_adv = ~bus.stall & ~(r_main.vld & ~w_go);
      w_acc = bus.in_vld[gp] & ~r_skid.vld;
    end

    // Main/skid update: skid always drains into main before new input
    always_ff @(posedge clk) begin
      if (rst) begin
        r_main <= '0;
        r_skid <= '0;
      end else if (w_adv) begin
        if (r_skid.vld) begin
          r_main     <= w_skid_snp;
          r_skid.vld <= 1'b0;
        end else if (bus.in_vld[gp]) begin
          r_main <= w_in_snp;
        end else begin
          r_main.vld <= 1'b0;
        end
      end else begin
        r_main <= w_main_snp;
        if (w_acc) begin
          r_skid <= w_in_snp;
        end else begin
          r_skid <= w_skid_snp;
        end
      end
    end

    // Outputs come straight from registers; in_rdy never depends on stall
    assign bus.in_rdy[gp]                                    = ~r_skid.vld;
    assign bus.out_vld[gp]                                   = r_main.vld;
    assign bus.out_go[gp]                                    = w_go;
    assign bus.out_dataA[gp*DATA_WIDTH +: DATA_WIDTH]        = r_main.data_a;
    assign bus.out_dataB[gp*DATA_WIDTH +: DATA_WIDTH]        = r_main.data_b;
    assign bus.out_dataS[gp*FLAGS_WIDTH +: FLAGS_WIDTH]      = r_main.data_s;
  end

endmodule

// File: tb/tb_rs_issue_operand_latch.sv
// Self-checking bench for rs_issue_operand_latch: directed scenarios plus randomized traffic.
// A reference model tracks in-flight instructions per port as ordered queues of operand sets.
// A monitor compares every presented output entry against the head of its port queue.
module tb_rs_issue_operand_latch;
  localparam int DW = 65;
  localparam int RW = 9;
  localparam int FW = 6;
  localparam int FC = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_issue_operand_latch_if #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .FLAGS_WIDTH(FW), .FU_COUNT(FC)) bus ();

  rs_issue_operand_latch #(.DATA_WIDTH(DW), .REG_WIDTH(RW), .FLAGS_WIDTH(FW), .FU_COUNT(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [FW-1:0] s;
    logic          pa;
    logic          pb;
    logic          ps;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [RW-1:0] rs;
  } op_t;

  op_t        mq [3][$];   // in-flight instructions per port, oldest first
  logic [2:0] acc;         // port accepted an issue at the last edge
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] oa(input int p);
    return bus.out_dataA[p*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] ob(input int p);
    return bus.out_dataB[p*DW +: DW];
  endfunction
  function automatic logic [FW-1:0] os(input int p);
    return bus.out_dataS[p*FW +: FW];
  endfunction

  // Reference writeback rule: first enabled FU (lowest index) with the awaited tag supplies the value
  function automatic op_t wb(input op_t e);
    op_t r;
    r = e;
    for (int k = 0; k < FC; k++) begin
      if (bus.FU_wen[k]) begin
        if (r.pa && bus.FU_reg[k*RW +: RW] == r.ra) begin
          r.a  = bus.FU_data[k*DW +: DW];
          r.pa = 1'b0;
        end
        if (r.pb && bus.FU_reg[k*RW +: RW] == r.rb) begin
          r.b  = bus.FU_data[k*DW +: DW];
          r.pb = 1'b0;
        end
        if (k < FC-1 && r.ps && bus.FU_reg[k*RW +: RW] == r.rs) begin
          r.s  = bus.FUS[k*FW +: FW];
          r.ps = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic op_t in_op(input int p);
    op_t r;
    r.a  = bus.in_dataA[p*DW +: DW];
    r.b  = bus.in_dataB[p*DW +: DW];
    r.s  = bus.in_dataS[p*FW +: FW];
    r.pa = bus.in_pendA[p];
    r.pb = bus.in_pendB[p];
    r.ps = bus.in_pendS[p];
    r.ra = bus.in_regA[p*RW +: RW];
    r.rb = bus.in_regB[p*RW +: RW];
    r.rs = bus.in_regS[p*RW +: RW];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // Reference model: every in-flight instruction snoops each edge; accepted issues join the queue
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int p = 0; p < 3; p++) mq[p].delete();
        acc = 3'b000;
      end else begin
        for (int p = 0; p < 3; p++) begin
          for (int i = 0; i < mq[p].size(); i++) mq[p][i] = wb(mq[p][i]);
          acc[p] = bus.in_vld[p] & bus.in_rdy[p];
          if (acc[p]) mq[p].push_back(wb(in_op(p)));
        end
      end
    end
  end

  // Monitor: compare any presented entry to the model head; pop when the FU takes it
  initial begin
    op_t  h;
    logic eg;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int p = 0; p < 3; p++) begin
          if (bus.out_vld[p]) begin
            if (mq[p].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL p%0d_spurious: out_vld=1 but no instruction in flight", p);
            end else begin
              h  = mq[p][0];
              eg = !(h.pa || h.pb || h.ps);
              chk($sformatf("p%0d_go", p), DW'(bus.out_go[p]), DW'(eg));
              if (eg && bus.out_go[p]) begin
                chk($sformatf("p%0d_dataA", p), oa(p), h.a);
                chk($sformatf("p%0d_dataB", p), ob(p), h.b);
                chk($sformatf("p%0d_dataS", p), DW'(os(p)), DW'(h.s));
                if (!bus.stall) void'(mq[p].pop_front());
              end
            end
          end else begin
            chk($sformatf("p%0d_go_idle", p), DW'(bus.out_go[p]), '0);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [FW-1:0] s,
                       input logic pa, input logic pb, input logic ps,
                       input logic [RW-1:0] ra, input logic [RW-1:0] rb, input logic [RW-1:0] rs);
    bus.in_vld[p]           = 1'b1;
    bus.in_dataA[p*DW +: DW] = a;
    bus.in_dataB[p*DW +: DW] = b;
    bus.in_dataS[p*FW +: FW] = s;
    bus.in_pendA[p]         = pa;
    bus.in_pendB[p]         = pb;
    bus.in_pendS[p]         = ps;
    bus.in_regA[p*RW +: RW]  = ra;
    bus.in_regB[p*RW +: RW]  = rb;
    bus.in_regS[p*RW +: RW]  = rs;
  endtask

  task automatic idle(input int p);
    bus.in_vld[p] = 1'b0;
  endtask

  task automatic fu(input int k, input logic [RW-1:0] r, input logic [DW-1:0] d, input logic [FW-1:0] f);
    bus.FU_wen[k]           = 1'b1;
    bus.FU_reg[k*RW +: RW]  = r;
    bus.FU_data[k*DW +: DW] = d;
    if (k < FC-1) bus.FUS[k*FW +: FW] = f;
  endtask

  task automatic fu_clear();
    bus.FU_wen = '0;
  endtask

  task automatic fu_random();
    for (int k = 0; k < FC; k++) begin
      if ($urandom_range(2) == 0) fu(k, RW'($urandom_range(7)), rnd_d(), FW'($urandom_range(63)));
      else bus.FU_wen[k] = 1'b0;
    end
  endtask

  task automatic issue_random(input int p);
    issue(p, rnd_d(), rnd_d(), FW'($urandom_range(63)),
          $urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0,
          RW'($urandom_range(7)), RW'($urandom_range(7)), RW'($urandom_range(7)));
  endtask

  initial begin
    logic drained;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.in_vld = '0;  bus.in_dataA = '0; bus.in_dataB = '0; bus.in_dataS = '0;
    bus.in_pendA = '0; bus.in_pendB = '0; bus.in_pendS = '0;
    bus.in_regA = '0; bus.in_regB = '0; bus.in_regS = '0;
    bus.FU_data = '0; bus.FU_reg = '0; bus.FU_wen = '0; bus.FUS = '0;
    cyc();
    cyc();

    // Reset state
    chk("rst_out_vld", DW'(bus.out_vld), '0);
    chk("rst_out_go",  DW'(bus.out_go), '0);
    chk("rst_in_rdy",  DW'(bus.in_rdy), DW'(3'b111));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rst_dataA%0d", p), oa(p), '0);
      chk($sformatf("rst_dataS%0d", p), DW'(os(p)), '0);
    end
    rst = 1'b0;
    cyc();

    // Pass-through on port 0
    issue(0, 65'h5, 65'h7, 6'h0, 1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0);
    cyc();
    idle(0);
    chk("pt_vld",   DW'(bus.out_vld[0]), DW'(1'b1));
    chk("pt_go",    DW'(bus.out_go[0]), DW'(1'b1));
    chk("pt_dataA", oa(0), 65'h5);
    chk("pt_dataB", ob(0), 65'h7);
    chk("pt_rdy",   DW'(bus.in_rdy), DW'(3'b111));
    cyc();
    chk("pt_gone",  DW'(bus.out_vld[0]), '0);

    // Skid on port 1
    issue(1, 65'h20, 65'h0, 6'h0, 1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0);
    cyc();
    bus.stall = 1'b1;
    issue(1, 65'h11, 65'h0, 6'h0, 1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0);
    cyc();
    idle(1);
    chk("sk_rdy_low", DW'(bus.in_rdy[1]), '0);
    chk("sk_hold",    oa(1), 65'h20);
    bus.stall = 1'b0;
    cyc();
    chk("sk_drain",   oa(1), 65'h11);
    chk("sk_rdy_hi",  DW'(bus.in_rdy[1]), DW'(1'b1));
    chk("sk_vld",     DW'(bus.out_vld[1]), DW'(1'b1));
    cyc();
    chk("sk_gone",    DW'(bus.out_vld[1]), '0);

    // Late wakeup on port 2
    issue(2, 65'h0, 65'h3, 6'h0, 1'b1, 1'b0, 1'b0, 9'h23, 9'h0, 9'h0);
    cyc();
    idle(2);
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_vld", DW'(bus.out_vld[2]), DW'(1'b1));
      chk("lw_wait_go",  DW'(bus.out_go[2]), '0);
      cyc();
    end
    fu(4, 9'h23, 65'hABC, 6'h0);
    cyc();
    fu_clear();
    chk("lw_dataA", oa(2), 65'hABC);
    chk("lw_go",    DW'(bus.out_go[2]), DW'(1'b1));
    cyc();

    // Capture-cycle bypass on port 0
    issue(0, 65'h1, 65'h0, 6'h0, 1'b0, 1'b1, 1'b0, 9'h0, 9'h40, 9'h0);
    fu(7, 9'h40, 65'h99, 6'h0);
    cyc();
    idle(0);
    fu_clear();
    chk("byp_dataB", ob(0), 65'h99);
    chk("byp_go",    DW'(bus.out_go[0]), DW'(1'b1));
    cyc();

    // Flags: lowest FU wins; the last FU has no flags bus
    issue(1, 65'h0, 65'h0, 6'h0, 1'b0, 1'b0, 1'b1, 9'h0, 9'h0, 9'h10);
    fu(2, 9'h10, 65'h222, 6'h01);
    fu(5, 9'h10, 65'h555, 6'h3F);
    cyc();
    idle(1);
    fu_clear();
    chk("fl_prio", DW'(os(1)), DW'(6'h01));
    chk("fl_go",   DW'(bus.out_go[1]), DW'(1'b1));
    cyc();
    issue(1, 65'h0, 65'h0, 6'h0, 1'b0, 1'b0, 1'b1, 9'h0, 9'h0, 9'h10);
    fu(9, 9'h10, 65'h999, 6'h0);
    cyc();
    idle(1);
    fu_clear();
    chk("fl_fu9_vld", DW'(bus.out_vld[1]), DW'(1'b1));
    chk("fl_fu9_go",  DW'(bus.out_go[1]), '0);
    fu(0, 9'h10, 65'h1, 6'h2A);
    cyc();
    fu_clear();
    chk("fl_late",    DW'(os(1)), DW'(6'h2A));
    chk("fl_late_go", DW'(bus.out_go[1]), DW'(1'b1));
    cyc();

    // Reset while main and skid are both full on every port
    for (int p = 0; p < 3; p++) issue(p, DW'(65'h100 + 65'(p)), 65'h0, 6'h0, 1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0);
    cyc();
    bus.stall = 1'b1;
    for (int p = 0; p < 3; p++) issue(p, DW'(65'h200 + 65'(p)), 65'h0, 6'h0, 1'b0, 1'b0, 1'b0, 9'h0, 9'h0, 9'h0);
    cyc();
    for (int p = 0; p < 3; p++) idle(p);
    chk("rs_full_rdy", DW'(bus.in_rdy), '0);
    chk("rs_full_vld", DW'(bus.out_vld), DW'(3'b111));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rs_vld", DW'(bus.out_vld), '0);
    chk("rs_go",  DW'(bus.out_go), '0);
    chk("rs_rdy", DW'(bus.in_rdy), DW'(3'b111));
    for (int p = 0; p < 3; p++) chk($sformatf("rs_dataA%0d", p), oa(p), '0);
    bus.stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rs_no_replay", DW'(bus.out_vld), '0);
    end

    // Randomized traffic; a refused request is held until accepted
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 3; p++) begin
        if (!(bus.in_vld[p] && !acc[p])) begin
          if ($urandom_range(1) == 0) issue_random(p);
          else idle(p);
        end
      end
      bus.stall = ($urandom_range(3) == 0);
      fu_random();
      cyc();
    end

    // Drain: no new issues, keep broadcasting so pending operands resolve
    drained = 1'b0;
    for (int c = 0; c < 500 && !drained; c++) begin
      bus.stall = 1'b0;
      for (int p = 0; p < 3; p++) if (!(bus.in_vld[p] && !acc[p])) idle(p);
      fu_random();
      cyc();
      drained = (bus.in_vld == 3'b000) && (mq[0].size() == 0) && (mq[1].size() == 0) && (mq[2].size() == 0);
    end
    n_tests++;
    if (!drained) begin
      n_fail++;
      $display("FAIL drain: instructions still in flight %0d/%0d/%0d, expected 0",
               mq[0].size(), mq[1].size(), mq[2].size());
    end
    fu_clear();
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
